push_encoder: RTL and testbench



---
 rtl/push_encoder.sv | 209 ++++++++++++++++++++
 tb/tb_push_encoder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/push_encoder.sv
`timescale 1ns/1ps
// push_encoder: conditions the raw up/down edit buttons into fixed-width
// command pulses, with auto-repeat while a single button is held.
//   clk      system clock
//   reset    asynchronous, active-high reset
//   enable   edit mode active; no commands are issued while low
//   btn_up   raw increment button (asynchronous, active-high)
//   btn_down raw decrement button (asynchronous, active-high)
//   push     registered command: 2'b10 up, 2'b01 down, 2'b00 none
//   busy     registered, high whenever the sequencer is not idle
module push_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned PULSE_CYCLES    = 4,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [1:0] push,
    output logic       busy
);

    localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned T_A   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned T_MAX = (T_A > PULSE_CYCLES) ? T_A : PULSE_CYCLES;
    localparam int unsigned TMR_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] PULSE_LAST  = TMR_W'(PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PULSE = 3'd1,
        S_HOLD  = 3'd2,
        S_RPT   = 3'd3,
        S_LOCK  = 3'd4
    } state_t;

    // Button vectors: bit 1 = up, bit 0 = down (same order as push).
    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            sync2_q, sync2_d;
    logic [1:0]            db_q, db_d;
    logic [1:0]            db_prev_q, db_prev_d;
    logic [1:0][DB_W-1:0]  dbc_q, dbc_d;
    logic [1:0]            settle_q, settle_d;
    logic                  armed_q, armed_d;

    state_t                state_q, state_d;
    logic                  dir_q, dir_d;       // 1 = up, 0 = down
    logic                  rpt_q, rpt_d;       // current pulse came from auto-repeat
    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic [1:0]            push_q, push_d;
    logic                  busy_q, busy_d;

    logic [1:0]            rise;
    logic                  held;
    logic                  other;

    assign rise  = db_q & ~db_prev_q;
    assign held  = dir_q ? db_q[1] : db_q[0];
    assign other = dir_q ? db_q[0] : db_q[1];
    assign push  = push_q;
    assign busy  = busy_q;

    // Synchronisers, debounce counters and press-edge history.
    always_comb begin
        sync1_d   = {btn_up, btn_down};
        sync2_d   = sync1_q;
        db_prev_d = db_q;
        db_d      = db_q;
        dbc_d     = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (dbc_q[i] == DB_LAST) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    dbc_d[i] = dbc_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Arming: after reset, a button already held must be released before it
    // can command. settle_q waits until the synchroniser reflects the pins.
    always_comb begin
        settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
        armed_d  = armed_q |
                   ((settle_q == 2'd2) && (sync2_q == 2'b00) && (db_q == 2'b00));
    end

    // Sequencer next-state and registered outputs.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        rpt_d   = rpt_q;
        tmr_d   = tmr_q;

        case (state_q)
            S_IDLE: begin
                rpt_d = 1'b0;
                tmr_d = '0;
                if (enable && armed_q) begin
                    if ((rise[1] && db_q[0]) || (rise[0] && db_q[1])) begin
                        state_d = S_LOCK;
                    end else if (rise[1]) begin
                        state_d = S_PULSE;
                        dir_d   = 1'b1;
                    end else if (rise[0]) begin
                        state_d = S_PULSE;
                        dir_d   = 1'b0;
                    end
                end
            end
            S_PULSE: begin
                if (tmr_q == PULSE_LAST) begin
                    tmr_d = '0;
                    if (other) begin
                        state_d = S_LOCK;
                    end else if (held) begin
                        state_d = rpt_q ? S_RPT : S_HOLD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_HOLD, S_RPT: begin
                // The opposite button never switches direction; it locks out.
                if (other) begin
                    state_d = S_LOCK;
                    tmr_d   = '0;
                end else if (!held) begin
                    state_d = S_IDLE;
                    tmr_d   = '0;
                end else if (tmr_q == ((state_q == S_HOLD) ? DELAY_LAST : PERIOD_LAST)) begin
                    state_d = S_PULSE;
                    rpt_d   = 1'b1;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_LOCK: begin
                tmr_d = '0;
                if (db_q == 2'b00) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                tmr_d   = '0;
            end
        endcase

        // Overrides from any active state; these truncate a pulse in progress.
        if (state_q != S_IDLE) begin
            if (!enable) begin
                state_d = S_IDLE;
                tmr_d   = '0;
            end else if (&db_q) begin
                state_d = S_LOCK;
                tmr_d   = '0;
            end
        end

        push_d = (state_d == S_PULSE) ? (dir_d ? 2'b10 : 2'b01) : 2'b00;
        busy_d = (state_d != S_IDLE);
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            dbc_q     <= '0;
            settle_q  <= '0;
            armed_q   <= 1'b0;
            state_q   <= S_IDLE;
            dir_q     <= 1'b0;
            rpt_q     <= 1'b0;
            tmr_q     <= '0;
            push_q    <= 2'b00;
            busy_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            dbc_q     <= dbc_d;
            settle_q  <= settle_d;
            armed_q   <= armed_d;
            state_q   <= state_d;
            dir_q     <= dir_d;
            rpt_q     <= rpt_d;
            tmr_q     <= tmr_d;
            push_q    <= push_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_push_encoder.sv
`timescale 1ns/1ps
// Testbench for push_encoder: per-cycle scoreboard fed by a timestamp-based
// reference model, directed scenarios plus randomized button traffic.
module tb_push_encoder;

    localparam int DEB    = 4;
    localparam int PULSE  = 4;
    localparam int DELAY  = 20;
    localparam int PERIOD = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [1:0] push;
    logic       busy;

    push_encoder #(
        .DEBOUNCE_CYCLES(DEB),
        .PULSE_CYCLES(PULSE),
        .REPEAT_DELAY(DELAY),
        .REPEAT_PERIOD(PERIOD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .push(push),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] push;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mon_cyc = 0;
    exp_t mon_e;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Modes of the command sequencer as seen from outside.
    localparam int M_IDLE = 0, M_PULSE = 1, M_WAIT = 2, M_LOCK = 3;

    bit [1:0] m_s1, m_s2, m_db, m_prev;
    int       m_run[2];
    int       m_since;
    bit       m_armed;
    int       m_mode;
    bit       m_dir;
    bit       m_rep;
    int       m_pend;   // step at which the current pulse is over
    int       m_fire;   // step at which the hold/repeat wait expires
    int       m_t;

    task automatic model_step(input bit rst, input bit en, input bit up, input bit dn);
        bit [1:0] db_o, rise_o, s2_o;
        bit       armed_o, held, other;
        int       nm;
        exp_t     e;
        m_t++;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_db = 0; m_prev = 0;
            m_run[0] = 0; m_run[1] = 0;
            m_since = 0; m_armed = 0;
            m_mode = M_IDLE; m_dir = 0; m_rep = 0;
            e.push = 2'b00; e.busy = 1'b0;
            exp_q.push_back(e);
            return;
        end
        db_o    = m_db;
        s2_o    = m_s2;
        rise_o  = m_db & ~m_prev;
        armed_o = m_armed;

        // Armed once the synchronised pins and debounced levels are all quiet.
        if (m_since >= 2 && s2_o == 2'b00 && db_o == 2'b00) m_armed = 1;
        m_since++;

        // A level is accepted after DEB consecutive disagreeing samples.
        for (int i = 0; i < 2; i++) begin
            if (s2_o[i] != db_o[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_db[i]  = s2_o[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_prev = db_o;
        m_s2   = m_s1;
        m_s1   = {up, dn};

        held  = m_dir ? db_o[1] : db_o[0];
        other = m_dir ? db_o[0] : db_o[1];
        nm    = m_mode;
        case (m_mode)
            M_IDLE: begin
                if (en && armed_o) begin
                    if ((rise_o[1] && db_o[0]) || (rise_o[0] && db_o[1])) begin
                        nm = M_LOCK;
                    end else if (rise_o != 2'b00) begin
                        nm     = M_PULSE;
                        m_dir  = rise_o[1];
                        m_rep  = 0;
                        m_pend = m_t + PULSE;
                    end
                end
            end
            M_PULSE: begin
                if (m_t == m_pend) begin
                    if (other) nm = M_LOCK;
                    else if (held) begin
                        nm     = M_WAIT;
                        m_fire = m_t + (m_rep ? PERIOD : DELAY);
                    end else nm = M_IDLE;
                end
            end
            M_WAIT: begin
                if (other) nm = M_LOCK;
                else if (!held) nm = M_IDLE;
                else if (m_t == m_fire) begin
                    nm     = M_PULSE;
                    m_rep  = 1;
                    m_pend = m_t + PULSE;
                end
            end
            default: begin
                if (db_o == 2'b00) nm = M_IDLE;
            end
        endcase
        if (m_mode != M_IDLE) begin
            if (!en) nm = M_IDLE;
            else if (db_o == 2'b11) nm = M_LOCK;
        end
        m_mode = nm;

        e.push = (nm == M_PULSE) ? (m_dir ? 2'b10 : 2'b01) : 2'b00;
        e.busy = (nm != M_IDLE);
        exp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_cyc++;
            if (push !== mon_e.push || busy !== mon_e.busy) begin
                n_cmp++;
                n_bad++;
                $display("FAIL cycle %0d push/busy: got %b/%b, expected %b/%b (t=%0t)",
                         mon_cyc, push, busy, mon_e.push, mon_e.busy, $time);
            end else begin
                n_cmp++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_cycle(input bit r, input bit e, input bit u, input bit d);
        @(negedge clk);
        reset = r; enable = e; btn_up = u; btn_down = d;
        model_step(r, e, u, d);
    endtask

    task automatic run(input bit e, input bit u, input bit d, input int n);
        repeat (n) do_cycle(1'b0, e, u, d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle.
        repeat (3) do_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        run(1, 0, 0, $urandom_range(5, 9));

        // Clean single press.
        run(1, 1, 0, 15);
        run(1, 0, 0, $urandom_range(25, 35));

        // Bouncing down button, then a steady level.
        for (int k = 0; k < 12; k++) do_cycle(1'b0, 1'b1, 1'b0, ((k / 2) % 2) == 0);
        run(1, 0, 1, 10);
        run(1, 0, 0, $urandom_range(25, 35));

        // Auto-repeat.
        run(1, 1, 0, 80);
        run(1, 0, 0, $urandom_range(25, 35));

        // Both buttons: down joins two cycles into the up pulse.
        run(1, 1, 0, 9);
        run(1, 1, 1, 20);
        run(1, 1, 0, 20);
        run(1, 0, 0, 20);
        run(1, 1, 0, 15);
        run(1, 0, 0, 30);

        // Enable gating.
        run(0, 0, 1, 10);
        run(1, 0, 1, 20);
        run(1, 0, 0, 20);
        run(1, 0, 1, 15);
        run(1, 0, 0, 30);

        // Asynchronous reset in the second cycle of an up pulse.
        run(1, 1, 0, 8);
        do_cycle(1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        chk("async_reset_push", int'(push), 0);
        chk("async_reset_busy", int'(busy), 0);
        do_cycle(1'b1, 1'b1, 1'b1, 1'b0);
        do_cycle(1'b1, 1'b1, 1'b1, 1'b0);
        run(1, 1, 0, 30);
        run(1, 0, 0, 20);
        run(1, 1, 0, 15);
        run(1, 0, 0, 30);

        // Randomized traffic, including enable drops and occasional resets.
        for (int s = 0; s < 60; s++) begin
            bit u, d, e;
            int n;
            u = 1'($urandom_range(0, 1));
            d = ($urandom_range(0, 3) == 0);
            e = ($urandom_range(0, 7) != 0);
            n = $urandom_range(1, 40);
            if ($urandom_range(0, 24) == 0) begin
                repeat ($urandom_range(1, 3)) do_cycle(1'b1, e, u, d);
            end
            run(e, u, d, n);
        end
        run(1, 0, 0, 40);

        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
